programmable_buzzer_multi: RTL

Parametrised multi-channel successor to the single-voice programmable buzzer: CHANNELS independent tone voices, each with its own note/octave command, a millisecond duration countdown, and a completion pulse. Voices are OR-mixed onto the buzzer port. The block sits on the peripheral bus next to the display, and the MIDI sequencer writes one command per note event.

---
 rtl/programmable_buzzer_multi.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/programmable_buzzer_multi.sv
// Multi-voice programmable buzzer: per-channel note/octave square wave with ms
// duration countdown, done pulse, OR-mixed buzzer output and per-channel readback.
module programmable_buzzer_multi #(
  parameter int unsigned CHANNELS      = 2,
  parameter int unsigned TONE_PRESCALE = 10,
  parameter int unsigned DUR_PRESCALE  = 10000,
  parameter int unsigned DUR_W         = 8,
  parameter int unsigned CW            = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en_i,
  input  logic [CW-1:0]         wr_chan_i,
  input  logic [8+DUR_W-1:0]    wr_data_i,
  input  logic [CW-1:0]         rd_chan_i,
  output logic [CHANNELS-1:0]   busy_o,
  output logic [CHANNELS-1:0]   done_o,
  output logic [CHANNELS-1:0]   tone_o,
  output logic [7:0]            buzzer_data_out,
  output logic [8+DUR_W-1:0]    bus_data_out
);

  localparam int unsigned DW  = 8 + DUR_W;
  localparam int unsigned TPW = (TONE_PRESCALE > 1) ? $clog2(TONE_PRESCALE) : 1;
  localparam int unsigned DPW = (DUR_PRESCALE > 1) ? $clog2(DUR_PRESCALE) : 1;

  typedef enum logic {IDLE = 1'b0, PLAY = 1'b1} state_t;

  function automatic logic [15:0] base_div(input logic [3:0] note);
    case (note)
      4'd0:    base_div = 16'd30581;
      4'd1:    base_div = 16'd28868;
      4'd2:    base_div = 16'd27248;
      4'd3:    base_div = 16'd25707;
      4'd4:    base_div = 16'd24272;
      4'd5:    base_div = 16'd22904;
      4'd6:    base_div = 16'd21626;
      4'd7:    base_div = 16'd20408;
      4'd8:    base_div = 16'd19260;
      4'd9:    base_div = 16'd18182;
      4'd10:   base_div = 16'd17159;
      default: base_div = 16'd16197;
    endcase
  endfunction

  logic [3:0]       wr_note;
  logic [3:0]       wr_oct;
  logic [DUR_W-1:0] wr_dur;
  logic [DW-1:0]    rd_bus [CHANNELS];

  assign wr_note = (wr_data_i[3:0] > 4'd11) ? 4'd11 : wr_data_i[3:0];
  assign wr_oct  = wr_data_i[7:4];
  assign wr_dur  = wr_data_i[DW-1:8];

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    state_t           state_q, state_d;
    logic [3:0]       note_q, note_d, oct_q, oct_d;
    logic [DUR_W-1:0] dur_q, dur_d;
    logic [TPW-1:0]   tpre_q, tpre_d;
    logic [DPW-1:0]   dpre_q, dpre_d;
    logic [15:0]      cnt_q, cnt_d;
    logic             tone_q, tone_d, done_q, done_d;
    logic [15:0]      shifted, divider;
    logic             wr_hit, stop_cmd, tone_tick, dur_tick, expire;

    assign wr_hit    = wr_en_i && (wr_chan_i == CW'(g));
    assign stop_cmd  = (wr_oct == 4'd0) && (wr_dur == '0);
    assign shifted   = base_div(note_q) >> oct_q;
    assign divider   = (shifted == 16'd0) ? 16'd0 : shifted - 16'd1;
    assign tone_tick = (tpre_q == TPW'(TONE_PRESCALE - 1));
    assign dur_tick  = (dpre_q == DPW'(DUR_PRESCALE - 1));
    assign expire    = (state_q == PLAY) && dur_tick && (dur_q == DUR_W'(1));

    // State and channel registers
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q <= IDLE;
        note_q  <= '0;
        oct_q   <= '0;
        dur_q   <= '0;
        tpre_q  <= '0;
        dpre_q  <= '0;
        cnt_q   <= '0;
        tone_q  <= 1'b0;
        done_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        note_q  <= note_d;
        oct_q   <= oct_d;
        dur_q   <= dur_d;
        tpre_q  <= tpre_d;
        dpre_q  <= dpre_d;
        cnt_q   <= cnt_d;
        tone_q  <= tone_d;
        done_q  <= done_d;
      end
    end

    // Next state: a write always wins over expiry
    always_comb begin
      state_d = state_q;
      if (wr_hit) begin
        state_d = stop_cmd ? IDLE : PLAY;
      end else if (expire) begin
        state_d = IDLE;
      end
    end

    // Datapath / registered outputs
    always_comb begin
      note_d = note_q;
      oct_d  = oct_q;
      dur_d  = dur_q;
      tpre_d = tpre_q;
      dpre_d = dpre_q;
      cnt_d  = cnt_q;
      tone_d = tone_q;
      done_d = 1'b0;
      if (wr_hit) begin
        note_d = wr_note;
        oct_d  = wr_oct;
        dur_d  = wr_dur;
        tpre_d = '0;
        dpre_d = '0;
        cnt_d  = '0;
        tone_d = 1'b0;
      end else if (state_q == PLAY) begin
        tpre_d = tone_tick ? '0 : tpre_q + TPW'(1);
        dpre_d = dur_tick ? '0 : dpre_q + DPW'(1);
        if (tone_tick && (oct_q != 4'd0)) begin
          if (cnt_q == divider) begin
            tone_d = ~tone_q;
            cnt_d  = '0;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        if (dur_tick && (dur_q != '0)) begin
          dur_d = dur_q - DUR_W'(1);
          if (expire) begin
            done_d = 1'b1;
            tone_d = 1'b0;
            tpre_d = '0;
            dpre_d = '0;
          end
        end
      end else begin
        tpre_d = '0;
        dpre_d = '0;
        tone_d = 1'b0;
      end
    end

    assign busy_o[g] = (state_q == PLAY);
    assign done_o[g] = done_q;
    assign tone_o[g] = tone_q;
    assign rd_bus[g] = {dur_q, oct_q, note_q};
  end

  // Readback mux; out-of-range channels read as zero
  always_comb begin
    bus_data_out = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (rd_chan_i == CW'(i)) bus_data_out = rd_bus[i];
    end
  end

  assign buzzer_data_out = {6'b111111, ~(|tone_o), |tone_o};

endmodule
